button_debounce: RTL and testbench

Parametrised multi-channel debouncer for mechanical buttons and toggles on active-low inputs. It synchronises each raw input and runs the last-bounce shift-register algorithm at the `tick` rate, with configurable shift length and don't-care depth. Per channel it outputs a clean level, one-cycle press and release pulses, and an optional long-press (hold) pulse. It sits between board pins and the UI/mode logic and replaces per-button ad-hoc edge detectors.

---
 rtl/debounce_pkg.sv | 26 ++
 rtl/debounce_chan.sv | 106 ++++++++++
 rtl/button_debounce.sv | 40 ++++
 tb/tb_button_debounce.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared masks, defaults and parameter legality check for the button debouncer
package debounce_pkg;

    // Default tick divider: clk cycles per sample strobe.
    localparam int DEFAULT_TICK_DIV = 4;

    // Top dc bits of an l-bit register set.
    function automatic logic [31:0] or_mask(input int l, input int dc);
        logic [63:0] m;
        m = ((64'd1 << dc) - 64'd1) << (l - dc);
        return m[31:0];
    endfunction

    // Top dc+1 bits of an l-bit register set.
    function automatic logic [31:0] comp_mask(input int l, input int dc);
        logic [63:0] m;
        m = ((64'd1 << (dc + 1)) - 64'd1) << (l - dc - 1);
        return m[31:0];
    endfunction

    // Legal: DC_BITS+2 <= L <= 32, at least two synchroniser stages, hold of at least one tick.
    function automatic bit params_ok(input int l, input int dc, input int ss, input int ht);
        return (dc >= 0) && (l >= dc + 2) && (l <= 32) && (ss >= 2) && (ht >= 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one debounce channel: synchroniser, last-bounce shift registers, pulses, optional hold counter (BUTTON_DEBOUNCE_HOLD_EN)
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int L           = 16,
    parameter int DC_BITS     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_TICKS  = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic state,
    output logic press,
    output logic release_pulse,
    output logic hold
);

    localparam logic [L-1:0] OR_M   = L'(or_mask(L, DC_BITS));
    localparam logic [L-1:0] COMP_M = L'(comp_mask(L, DC_BITS));

    generate
        if (!params_ok(L, DC_BITS, SYNC_STAGES, HOLD_TICKS)) begin : g_bad_params
            $error("debounce_chan: illegal L/DC_BITS/SYNC_STAGES/HOLD_TICKS combination");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [L-1:0]           sh_press;
    logic [L-1:0]           sh_release;
    logic                   press_hit;
    logic                   release_hit;

    assign s = sync[SYNC_STAGES-1];

    // Matches use the pre-update shift values; press wins if both ever matched.
    assign press_hit   = tick && (sh_press == COMP_M) && state;
    assign release_hit = tick && !press_hit && (sh_release == COMP_M) && !state;

    // Synchroniser chain; resets to "open" so a closed button reads as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    // Last-bounce shift registers, advanced only on tick; the all-1 fill is the preceding "one".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_press   <= '1;
            sh_release <= '1;
        end else if (tick) begin
            sh_press   <= {sh_press[L-2:0], s} | OR_M;
            sh_release <= {sh_release[L-2:0], ~s} | OR_M;
        end
    end

    // Debounced level and single-cycle edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= 1'b1;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= press_hit;
            release_pulse <= release_hit;
            if (press_hit) begin
                state <= 1'b0;
            end else if (release_hit) begin
                state <= 1'b1;
            end
        end
    end

`ifdef BUTTON_DEBOUNCE_HOLD_EN
    localparam int             CW       = $clog2(HOLD_TICKS + 1);
    localparam logic [CW-1:0]  HOLD_MAX = CW'(HOLD_TICKS);

    logic [CW-1:0] cnt;

    // Long-press counter: saturates so hold fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            hold <= 1'b0;
        end else begin
            hold <= 1'b0;
            if (press_hit || release_hit) begin
                cnt <= '0;
            end else if (tick && !state && (cnt != HOLD_MAX)) begin
                cnt <= cnt + 1'b1;
                if (cnt == HOLD_MAX - 1'b1) begin
                    hold <= 1'b1;
                end
            end
        end
    end
`else
    assign hold = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - N-channel active-low button debouncer; hold pulses only with BUTTON_DEBOUNCE_HOLD_EN
module button_debounce
    import debounce_pkg::*;
#(
    parameter int N           = 8,
    parameter int L           = 16,
    parameter int DC_BITS     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_TICKS  = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic [N-1:0] raw_in,
    output logic [N-1:0] state,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] hold
);

    // Channels are fully independent; one detector per input pin.
    for (genvar i = 0; i < N; i++) begin : g_chan
        debounce_chan #(
            .L           (L),
            .DC_BITS     (DC_BITS),
            .SYNC_STAGES (SYNC_STAGES),
            .HOLD_TICKS  (HOLD_TICKS)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .tick          (tick),
            .raw           (raw_in[i]),
            .state         (state[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .hold          (hold[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - table-driven self-checking bench for button_debounce
module tb_button_debounce;
    import debounce_pkg::*;

    localparam logic [3:0] HMASK =
`ifdef BUTTON_DEBOUNCE_HOLD_EN
        4'hF;
`else
        4'h0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [3:0] raw_in;
    logic [3:0] state;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] hold;

    int passed = 0;
    int total  = 0;
    int press_cnt [4];
    int rel_cnt   [4];
    int hold_cnt  [4];

    typedef struct {
        int         reps;
        logic [3:0] raw;
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] hd;
    } vec_t;

    vec_t tbl[$];

    button_debounce #(
        .N(4), .L(16), .DC_BITS(3), .SYNC_STAGES(2), .HOLD_TICKS(20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick          (tick),
        .raw_in        (raw_in),
        .state         (state),
        .press         (press),
        .release_pulse (rel),
        .hold          (hold)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (press[i]) press_cnt[i]++;
                if (rel[i])   rel_cnt[i]++;
                if (hold[i])  hold_cnt[i]++;
            end
        end
    end

    function automatic void add(input int reps, input logic [3:0] raw, input logic [3:0] st,
                                input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] hd);
        vec_t v;
        v.reps = reps; v.raw = raw; v.st = st; v.pr = pr; v.rl = rl; v.hd = hd;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // One sample period; the value v is what the tick samples. Returns #1 after the tick edge.
    task automatic run_tick(input logic [3:0] v);
        @(negedge clk);
        raw_in = v;
        tick   = 1'b0;
        repeat (DEFAULT_TICK_DIV - 2) @(negedge clk);
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    initial begin
        logic [3:0] acc;
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; hold_cnt[i] = 0;
        end
        rst_n = 1'b0; tick = 1'b0; raw_in = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", state, 4'hF);
        check("reset_press", press, 4'h0);
        check("reset_release", rel, 4'h0);
        check("reset_hold", hold, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // reps, raw, state, press, release, hold (expectations on the last tick of the row)
        add(100, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        add(12,  4'hE, 4'hF, 4'h0, 4'h0, 4'h0);
        add(1,   4'hE, 4'hE, 4'h1, 4'h0, 4'h0);
        add(5,   4'hE, 4'hE, 4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 5; k++) begin
            add(1, 4'hC, 4'hE, 4'h0, 4'h0, 4'h0);
            add(1, 4'hE, 4'hE, 4'h0, 4'h0, 4'h0);
        end
        add(4,   4'hC, 4'hE, 4'h0, 4'h0, 4'h0);
        add(1,   4'hC, 4'hE, 4'h0, 4'h0, 4'h1);
        add(7,   4'hC, 4'hE, 4'h0, 4'h0, 4'h0);
        add(1,   4'hC, 4'hC, 4'h2, 4'h0, 4'h0);
        add(11,  4'h8, 4'hC, 4'h0, 4'h0, 4'h0);
        add(8,   4'hC, 4'hC, 4'h0, 4'h0, 4'h0);
        add(1,   4'hC, 4'hC, 4'h0, 4'h0, 4'h2);
        add(11,  4'hC, 4'hC, 4'h0, 4'h0, 4'h0);
        add(12,  4'h8, 4'hC, 4'h0, 4'h0, 4'h0);
        add(1,   4'hC, 4'h8, 4'h4, 4'h0, 4'h0);
        add(11,  4'hC, 4'h8, 4'h0, 4'h0, 4'h0);
        add(1,   4'hC, 4'hC, 4'h0, 4'h4, 4'h0);
        add(12,  4'h4, 4'hC, 4'h0, 4'h0, 4'h0);
        add(1,   4'h4, 4'h4, 4'h8, 4'h0, 4'h0);
        add(19,  4'h4, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1,   4'h4, 4'h4, 4'h0, 4'h0, 4'h8);
        add(30,  4'h4, 4'h4, 4'h0, 4'h0, 4'h0);

        foreach (tbl[r]) begin
            acc = 4'h0;
            for (int k = 0; k < tbl[r].reps; k++) begin
                run_tick(tbl[r].raw);
                if (k < tbl[r].reps - 1) acc |= press | rel;
            end
            check($sformatf("row%0d_state", r), state, tbl[r].st);
            check($sformatf("row%0d_press", r), press, tbl[r].pr);
            check($sformatf("row%0d_release", r), rel, tbl[r].rl);
            check($sformatf("row%0d_hold", r), hold, tbl[r].hd & HMASK);
            check($sformatf("row%0d_no_early_pulse", r), acc, 4'h0);
        end

        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("press_count%0d", i), press_cnt[i], 1);
            check($sformatf("release_count%0d", i), rel_cnt[i], (i == 2) ? 1 : 0);
            check($sformatf("hold_count%0d", i), hold_cnt[i], (HMASK[i] && i != 2) ? 1 : 0);
        end

        // Channel 0 closed through reset: the reset fill acts as the preceding open level.
        rst_n = 1'b0; raw_in = 4'hE;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc = 4'h0;
        for (int k = 0; k < 12; k++) begin
            run_tick(4'hE);
            acc |= press | rel | ~state;
        end
        check("rst_closed_no_early", acc, 4'h0);
        run_tick(4'hE);
        check("rst_closed_press", press, 4'h1);
        check("rst_closed_state", state, 4'hE);

        // Reset while the press pulse is high must clear it without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_press", press, 4'h0);
        check("async_rst_state", state, 4'hF);

        // Reset partway through a stable count restarts it from the fill.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) run_tick(4'hC);
        #2;
        rst_n = 1'b0;
        #1;
        check("midcount_rst_state", state, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        acc = 4'h0;
        for (int k = 0; k < 12; k++) begin
            run_tick(4'hC);
            acc |= press | rel;
        end
        check("midcount_no_early", acc, 4'h0);
        run_tick(4'hC);
        check("midcount_press", press, 4'h3);
        check("midcount_state", state, 4'hC);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
